// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data cache to single RAM port arbiter, data priority with starvation guard
module mem_arbiter #(
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] RAM_FREE     = 2'b00,
    parameter logic [1:0] RAM_BUSY     = 2'b01,
    parameter logic [1:0] RAM_ACCESS   = 2'b10,
    parameter logic [1:0] RAM_ERROR    = 2'b11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       ram_error_q, ram_error_d;
    logic       dreq;

    assign dreq      = dREN | dWEN;
    assign ram_error = ram_error_q;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        ram_error_d = ram_error_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;

        case (state_q)
            IDLE: begin
                // streak counts data grants issued while a fetch was left waiting
                if (iREN && (streak_q == LIMIT || !dreq)) begin
                    state_d  = I_ACC;
                    streak_d = '0;
                end else if (dreq) begin
                    state_d = D_ACC;
                    if (iREN)
                        streak_d = (streak_q == LIMIT) ? streak_q : streak_q + 4'd1;
                    else
                        streak_d = '0;
                end else begin
                    streak_d = '0;
                end
            end

            D_ACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    case (ramstate)
                        RAM_ACCESS: begin
                            dwait   = 1'b0;
                            dload   = ramload;
                            state_d = IDLE;
                        end
                        RAM_ERROR: begin
                            ram_error_d = 1'b1;
                            state_d     = IDLE;
                        end
                        RAM_FREE, RAM_BUSY: ;
                        default: ;
                    endcase
                end
            end

            I_ACC: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    case (ramstate)
                        RAM_ACCESS: begin
                            iwait   = 1'b0;
                            iload   = ramload;
                            state_d = IDLE;
                        end
                        RAM_ERROR: begin
                            ram_error_d = 1'b1;
                            state_d     = IDLE;
                        end
                        RAM_FREE, RAM_BUSY: ;
                        default: ;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            ram_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            ram_error_q <= ram_error_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_error;

    int n_assert = 0;
    int n_fail   = 0;
    int izero    = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_error(ram_error)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ramREN"}, {31'd0, ramREN}, 32'd0);
        chk({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
        chk({tag, "_iwait"},  {31'd0, iwait},  32'd1);
        chk({tag, "_dwait"},  {31'd0, dwait},  32'd1);
    endtask

    initial begin
        RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
        step();
        step();
        RST = 1'b0;
        #2;
        chk_idle("rst");
        chk("rst_ramaddr",  ramaddr,  32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iload",    iload,    32'd0);
        chk("rst_dload",    dload,    32'd0);
        chk("rst_ram_error", {31'd0, ram_error}, 32'd0);

        // T1: single read, immediate ACCESS
        dREN = 1; daddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk("t1_c0_ramREN", {31'd0, ramREN}, 32'd0);
        step();
        chk("t1_c1_ramREN",  {31'd0, ramREN}, 32'd1);
        chk("t1_c1_ramaddr", ramaddr, 32'h40);
        chk("t1_c1_dwait",   {31'd0, dwait}, 32'd0);
        chk("t1_c1_dload",   dload, 32'hDEADBEEF);
        chk("t1_c1_iwait",   {31'd0, iwait}, 32'd1);
        step();
        chk_idle("t1_c2");
        chk("t1_c2_dload", dload, 32'd0);
        dREN = 0; ramstate = FREE;
        step();

        // T2: write with three BUSY cycles then ACCESS
        dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = BUSY;
        #1;
        chk("t2_arb_ramWEN", {31'd0, ramWEN}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            ramstate = (i == 3) ? ACCESS : BUSY;
            #1;
            chk($sformatf("t2_c%0d_ramWEN", i),   {31'd0, ramWEN}, 32'd1);
            chk($sformatf("t2_c%0d_ramREN", i),   {31'd0, ramREN}, 32'd0);
            chk($sformatf("t2_c%0d_ramstore", i), ramstore, 32'h12345678);
            chk($sformatf("t2_c%0d_ramaddr", i),  ramaddr, 32'h80);
            chk($sformatf("t2_c%0d_dwait", i),    {31'd0, dwait}, (i == 3) ? 32'd0 : 32'd1);
            chk($sformatf("t2_c%0d_iwait", i),    {31'd0, iwait}, 32'd1);
        end
        step();
        dWEN = 0; ramstate = FREE;
        #1;
        chk_idle("t2_end");
        step();

        // T3: both requesters held, starvation guard every fifth grant
        iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h104; ramstate = ACCESS; ramload = 32'hA5A5_0001;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (iwait == 1'b0) izero++;
            if (k % 2 == 0) begin
                chk($sformatf("t3_w%0d_idle_ramREN", k), {31'd0, ramREN}, 32'd0);
            end else begin
                automatic int  g     = k / 2;
                automatic bit  is_i  = (g == 4) || (g == 9);
                chk($sformatf("t3_g%0d_ramREN", g),  {31'd0, ramREN}, 32'd1);
                chk($sformatf("t3_g%0d_ramaddr", g), ramaddr, is_i ? 32'h100 : 32'h104);
                chk($sformatf("t3_g%0d_iwait", g),   {31'd0, iwait}, is_i ? 32'd0 : 32'd1);
                chk($sformatf("t3_g%0d_dwait", g),   {31'd0, dwait}, is_i ? 32'd1 : 32'd0);
            end
            step();
        end
        chk("t3_iwait_zero_count", izero, 32'd2);
        iREN = 0; dREN = 0; ramstate = FREE;
        step();

        // T4: fetch alone; late data request must not disturb the RAM address
        iREN = 1; iaddr = 32'h200; ramstate = BUSY;
        #1;
        chk("t4_arb_ramREN", {31'd0, ramREN}, 32'd0);
        step();
        chk("t4_c1_ramREN",   {31'd0, ramREN}, 32'd1);
        chk("t4_c1_ramWEN",   {31'd0, ramWEN}, 32'd0);
        chk("t4_c1_ramaddr",  ramaddr, 32'h200);
        chk("t4_c1_ramstore", ramstore, 32'd0);
        chk("t4_c1_dwait",    {31'd0, dwait}, 32'd1);
        dREN = 1; daddr = 32'h300;
        #1;
        chk("t4_c1b_ramaddr", ramaddr, 32'h200);
        step();
        chk("t4_c2_ramaddr", ramaddr, 32'h200);
        chk("t4_c2_dload",   dload, 32'd0);
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        #1;
        chk("t4_c3_ramaddr", ramaddr, 32'h200);
        chk("t4_c3_iwait",   {31'd0, iwait}, 32'd0);
        chk("t4_c3_iload",   iload, 32'hCAFEF00D);
        chk("t4_c3_dwait",   {31'd0, dwait}, 32'd1);
        step();
        iREN = 0;
        #1;
        chk_idle("t4_idle");
        step();
        chk("t4_d_ramaddr", ramaddr, 32'h300);
        chk("t4_d_dwait",   {31'd0, dwait}, 32'd0);
        dREN = 0; ramstate = FREE;
        step();

        // T5: error on first attempt, sticky flag, retried grant
        dREN = 1; daddr = 32'h500; ramstate = ERROR;
        #1;
        chk("t5_arb_ram_error", {31'd0, ram_error}, 32'd0);
        step();
        chk("t5_err_ramREN",    {31'd0, ramREN}, 32'd1);
        chk("t5_err_dwait",     {31'd0, dwait}, 32'd1);
        chk("t5_err_ram_error", {31'd0, ram_error}, 32'd0);
        step();
        ramstate = ACCESS; ramload = 32'h55AA55AA;
        #1;
        chk_idle("t5_idle");
        chk("t5_idle_ram_error", {31'd0, ram_error}, 32'd1);
        step();
        chk("t5_retry_ramaddr",   ramaddr, 32'h500);
        chk("t5_retry_dwait",     {31'd0, dwait}, 32'd0);
        chk("t5_retry_dload",     dload, 32'h55AA55AA);
        chk("t5_retry_ram_error", {31'd0, ram_error}, 32'd1);
        dREN = 0; ramstate = FREE;
        step();
        step();
        chk("t5_held_ram_error", {31'd0, ram_error}, 32'd1);

        // T6: reset in the middle of a busy data access
        iREN = 1; iaddr = 32'h600; dREN = 1; daddr = 32'h700; ramstate = BUSY;
        step();
        chk("t6_dacc_ramaddr", ramaddr, 32'h700);
        chk("t6_dacc_streak",  {28'd0, dut.streak_q}, 32'd1);
        RST = 1;
        step();
        RST = 0;
        #1;
        chk_idle("t6_rst");
        chk("t6_rst_streak",    {28'd0, dut.streak_q}, 32'd0);
        chk("t6_rst_ram_error", {31'd0, ram_error}, 32'd0);
        iREN = 0; ramstate = ACCESS; ramload = 32'h0BADF00D;
        step();
        chk("t6_regrant_ramaddr", ramaddr, 32'h700);
        chk("t6_regrant_dwait",   {31'd0, dwait}, 32'd0);
        dREN = 0; ramstate = FREE;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-CPU memory arbiter directly downstream of the instruction cache and the data cache.
- Serializes their word requests onto one shared RAM port and returns per-cache wait/load signals.
- Data cache has priority. A starvation counter guarantees forward progress for instruction fetch.
- One word per grant. Arbitration decision is registered, so there is one idle cycle between words.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants issued while an instruction request is pending before the instruction side is forced a grant (legal range 1..15).
- RAM_FREE, 2'b00: ramstate encoding, RAM idle.
- RAM_BUSY, 2'b01: ramstate encoding, access in progress.
- RAM_ACCESS, 2'b10: ramstate encoding, access completes this cycle.
- RAM_ERROR, 2'b11: ramstate encoding, access failed.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  0 = iload valid / request completed this cycle.
- iload  out  32  instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  0 = dcache access completed this cycle.
- dload  out  32  data word.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==RAM_ACCESS.
- ramstate  in  2  RAM status per encodings above.
- ram_error  out  1  sticky; set on any RAM_ERROR while granted.

Behaviour:
- Reset (RST high at an edge):
  - state=IDLE, streak=0, ram_error=0.
  - Outputs while in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
  - Reset mid-access drops the RAM request from the next cycle on. The interrupted requester keeps wait=1 and is re-arbitrated after reset.
- States: IDLE, D_ACC, I_ACC.
- IDLE:
  - No RAM request is driven.
  - Arbitration uses dreq=dREN|dWEN and the current iREN.
  - If iREN and (streak==STARVE_LIMIT or !dreq): next=I_ACC, streak<=0.
  - Else if dreq: next=D_ACC. streak<=streak+1 if iREN, else streak<=0 (streak saturates at STARVE_LIMIT).
  - Else: stay IDLE, streak<=0.
- D_ACC:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN and ramREN=dREN&!dWEN (write wins if both asserted). iwait=1.
  - ramstate==RAM_ACCESS: dwait=0 and dload=ramload for exactly that cycle; next=IDLE.
  - ramstate==RAM_ERROR: dwait=1, ram_error<=1, next=IDLE (request retried on re-grant).
  - FREE/BUSY: dwait=1, dload=0, stay.
  - dREN|dWEN drops while granted: abort. RAM enables drop combinationally that cycle and next=IDLE.
- I_ACC:
  - Mirror of D_ACC using iREN/iaddr/iwait/iload. ramWEN=0 always.
  - ramstore=0.
  - dwait=1.
- Latency: minimum 2 cycles per word (1 arbitration + 1 access with immediate RAM_ACCESS). Back-to-back words from one requester see a 1-cycle IDLE bubble.
- Data outputs of the non-granted side are 0. Its wait is 1.
- The RAM port sees changes only from the granted requester. iaddr/daddr of the non-owner never reach ramaddr.
- ram_error clears only on RST.

Test Plan:
1. Reset, then dREN=1 with daddr=0x40 and RAM returning ACCESS on the first cycle with ramload=0xDEADBEEF. Required: cycle 0 IDLE with ramREN=0; cycle 1 ramREN=1, ramaddr=0x40, dwait=0, dload=0xDEADBEEF; cycle 2 IDLE.
2. dWEN=1 with daddr=0x80, dstore=0x12345678, and ramstate BUSY for 3 cycles then ACCESS. Required: ramWEN=1 and ramstore=0x12345678 held for 4 cycles; dwait=0 only in the 4th cycle; iwait=1 throughout.
3. iREN and dREN both held continuously with STARVE_LIMIT=4 and instant ACCESS. Required grant order D,D,D,D,I,D,D,D,D,I. iwait=0 exactly once per 5 grants.
4. iREN alone with iaddr=0x200 while the dcache is idle. Required: I_ACC with ramREN=1 and ramaddr=0x200. A dREN raised mid-access with daddr=0x300 does not change ramaddr until the next IDLE.
5. dREN granted and ramstate=ERROR for one cycle, then ACCESS. Required: ram_error=1 from the next cycle onward and held; FSM passes through IDLE and re-grants D; dwait=0 on the later ACCESS.
6. RST asserted while in D_ACC with ramstate=BUSY. Required: next cycle ramREN=ramWEN=0, dwait=1, streak=0, ram_error=0.
